uart_memloader: RTL and testbench

//   Parametrised successor to the UART memory flasher. Parses framed UART

---
 rtl/uart_memloader.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_memloader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_memloader.sv
// uart_memloader: parses framed UART bytes into word writes on a memory
// write port and answers each frame with a one-byte ACK/NAK reply.
//
// Frame: START_BYTE, ADDR[4] LE, LEN[4] LE, DATA[LEN], CSUM (XOR of the
// ADDR, LEN and DATA bytes).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rx_valid, rx_byte   received byte strobe and value
//   tx_ready            reply sink can accept tx_byte
//   tx_valid, tx_byte   reply byte, held until tx_ready
//   flash_active        high from start byte until reply accepted
//   flash_addr/data/wen word write port (one-cycle strobe)
//   flash_done          pulse when reply accepted
//   flash_err           sticky NAK flag, cleared at next start byte
module uart_memloader #(
  parameter int          WORD_BYTES  = 4,
  parameter int          ADDR_W      = 32,
  parameter logic [7:0]  START_BYTE  = 8'hAA,
  parameter logic [7:0]  ACK_BYTE    = 8'h55,
  parameter logic [7:0]  NAK_BYTE    = 8'hEE,
  parameter int          TIMEOUT_CYC = 1000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_byte,
  input  logic                    tx_ready,
  output logic                    tx_valid,
  output logic [7:0]              tx_byte,
  output logic                    flash_active,
  output logic [ADDR_W-1:0]       flash_addr,
  output logic [8*WORD_BYTES-1:0] flash_data,
  output logic                    flash_wen,
  output logic                    flash_done,
  output logic                    flash_err
);

  localparam int WB_LOG2 = $clog2(WORD_BYTES);
  localparam int LW      = (WORD_BYTES > 1) ? WB_LOG2 : 1;
  localparam int TW      = $clog2(TIMEOUT_CYC + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_LEN  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_CSUM = 3'd4;
  localparam logic [2:0] S_RESP = 3'd5;

  logic [2:0]              state_q, state_d;
  logic [1:0]              hdr_q, hdr_d;
  logic [31:0]             addr_q, addr_d;
  logic [31:0]             len_q, len_d;
  logic [31:0]             cnt_q, cnt_d;
  logic [8*WORD_BYTES-1:0] wbuf_q, wbuf_d;
  logic [7:0]              csum_q, csum_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    txv_q, txv_d;
  logic [7:0]              txb_q, txb_d;
  logic                    act_q, act_d;
  logic [ADDR_W-1:0]       faddr_q, faddr_d;
  logic [8*WORD_BYTES-1:0] fdata_q, fdata_d;
  logic                    wen_q, wen_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic [LW-1:0]           lane;
  logic [8*WORD_BYTES-1:0] word_next;
  logic [31:0]             waddr;
  logic                    in_frame;
  logic                    last_byte;

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    wbuf_d  = wbuf_q;
    csum_d  = csum_q;
    timer_d = timer_q;
    txv_d   = txv_q;
    txb_d   = txb_q;
    act_d   = act_q;
    faddr_d = faddr_q;
    fdata_d = fdata_q;
    wen_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;

    // Lane 0 starts a fresh word, so a short final word is zero-filled above.
    lane      = (WORD_BYTES == 1) ? '0 : cnt_q[LW-1:0];
    word_next = (lane == '0) ? '0 : wbuf_q;
    word_next[8*int'(lane) +: 8] = rx_byte;
    waddr     = (addr_q >> WB_LOG2) + (cnt_q >> WB_LOG2);
    last_byte = (cnt_q + 32'd1 == len_q);
    in_frame  = (state_q == S_ADDR) || (state_q == S_LEN) ||
                (state_q == S_DATA) || (state_q == S_CSUM);

    if (in_frame) begin
      if (rx_valid)
        timer_d = '0;
      else
        timer_d = timer_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_byte == START_BYTE) begin
          state_d = S_ADDR;
          act_d   = 1'b1;
          err_d   = 1'b0;
          hdr_d   = '0;
          addr_d  = '0;
          len_d   = '0;
          cnt_d   = '0;
          csum_d  = '0;
          timer_d = '0;
        end
      end
      S_ADDR: begin
        if (rx_valid) begin
          addr_d = {rx_byte, addr_q[31:8]};
          csum_d = csum_q ^ rx_byte;
          hdr_d  = hdr_q + 2'd1;
          if (hdr_q == 2'd3) state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (rx_valid) begin
          len_d  = {rx_byte, len_q[31:8]};
          csum_d = csum_q ^ rx_byte;
          hdr_d  = hdr_q + 2'd1;
          if (hdr_q == 2'd3)
            state_d = ({rx_byte, len_q[31:8]} == 32'd0) ? S_CSUM : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          csum_d = csum_q ^ rx_byte;
          wbuf_d = word_next;
          cnt_d  = cnt_q + 32'd1;
          if (int'(lane) == WORD_BYTES - 1 || last_byte) begin
            wen_d   = 1'b1;
            faddr_d = ADDR_W'(waddr);
            fdata_d = word_next;
          end
          if (last_byte) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (rx_valid) begin
          state_d = S_RESP;
          txv_d   = 1'b1;
          if (rx_byte == csum_q) begin
            txb_d = ACK_BYTE;
          end else begin
            txb_d = NAK_BYTE;
            err_d = 1'b1;
          end
        end
      end
      S_RESP: begin
        if (tx_ready) begin
          state_d = S_IDLE;
          txv_d   = 1'b0;
          done_d  = 1'b1;
          act_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Timeout wins only on a byte-free cycle, so it never races a case update.
    if (in_frame && !rx_valid && timer_q == TW'(TIMEOUT_CYC - 1)) begin
      state_d = S_RESP;
      txv_d   = 1'b1;
      txb_d   = NAK_BYTE;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hdr_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      wbuf_q  <= '0;
      csum_q  <= '0;
      timer_q <= '0;
      txv_q   <= 1'b0;
      txb_q   <= '0;
      act_q   <= 1'b0;
      faddr_q <= '0;
      fdata_q <= '0;
      wen_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      wbuf_q  <= wbuf_d;
      csum_q  <= csum_d;
      timer_q <= timer_d;
      txv_q   <= txv_d;
      txb_q   <= txb_d;
      act_q   <= act_d;
      faddr_q <= faddr_d;
      fdata_q <= fdata_d;
      wen_q   <= wen_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign tx_valid     = txv_q;
  assign tx_byte      = txb_q;
  assign flash_active = act_q;
  assign flash_addr   = faddr_q;
  assign flash_data   = fdata_q;
  assign flash_wen    = wen_q;
  assign flash_done   = done_q;
  assign flash_err    = err_q;

endmodule

// File: tb/tb_uart_memloader.sv
module tb_uart_memloader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-byte-word instance
  logic        r4, v4, rdy4, t4v, act4, w4, d4, e4;
  logic [7:0]  b4, t4b;
  logic [31:0] fa4, fd4;
  // 1-byte-word instance
  logic        r1, v1, rdy1, t1v, act1, w1, d1, e1;
  logic [7:0]  b1, t1b, fd1;
  logic [31:0] fa1;

  uart_memloader #(.WORD_BYTES(4), .ADDR_W(32), .TIMEOUT_CYC(50)) u_w4 (
    .clk(clk), .rst_n(r4), .rx_valid(v4), .rx_byte(b4), .tx_ready(rdy4),
    .tx_valid(t4v), .tx_byte(t4b), .flash_active(act4), .flash_addr(fa4),
    .flash_data(fd4), .flash_wen(w4), .flash_done(d4), .flash_err(e4));

  uart_memloader #(.WORD_BYTES(1), .ADDR_W(32), .TIMEOUT_CYC(50)) u_w1 (
    .clk(clk), .rst_n(r1), .rx_valid(v1), .rx_byte(b1), .tx_ready(rdy1),
    .tx_valid(t1v), .tx_byte(t1b), .flash_active(act1), .flash_addr(fa1),
    .flash_data(fd1), .flash_wen(w1), .flash_done(d1), .flash_err(e1));

  typedef struct {logic [31:0] a; logic [63:0] d;} wr_t;
  wr_t        q4[$], q1[$], e4w, e1w;
  logic [7:0] rq[$], dq[$], fq[$];
  int         n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (w4) begin
      if (q4.size() == 0) chk("w4_unexpected_wen", w4, 0);
      else begin
        e4w = q4.pop_front();
        chk("w4_addr", fa4, e4w.a);
        chk("w4_data", fd4, e4w.d);
      end
    end
    if (w1) begin
      if (q1.size() == 0) chk("w1_unexpected_wen", w1, 0);
      else begin
        e1w = q1.pop_front();
        chk("w1_addr", fa1, e1w.a);
        chk("w1_data", fd1, e1w.d);
      end
    end
  end

  function automatic logic o_tv(input bit s); return s ? t1v : t4v; endfunction
  function automatic logic [7:0] o_tb(input bit s); return s ? t1b : t4b; endfunction
  function automatic logic o_done(input bit s); return s ? d1 : d4; endfunction
  function automatic logic o_act(input bit s); return s ? act1 : act4; endfunction

  task automatic build_frame(input logic [31:0] addr, input bit corrupt);
    logic [7:0]  cs;
    logic [31:0] len;
    cs  = 8'h00;
    len = dq.size();
    fq  = {};
    fq.push_back(8'hAA);
    for (int i = 0; i < 4; i++) begin fq.push_back(addr[8*i +: 8]); cs ^= addr[8*i +: 8]; end
    for (int i = 0; i < 4; i++) begin fq.push_back(len[8*i +: 8]);  cs ^= len[8*i +: 8];  end
    foreach (dq[i]) begin fq.push_back(dq[i]); cs ^= dq[i]; end
    fq.push_back(corrupt ? (cs ^ 8'h01) : cs);
  endtask

  task automatic push_exp(input bit s, input logic [31:0] addr);
    int  wb, sh, nw, idx;
    wr_t e;
    wb = s ? 1 : 4;
    sh = s ? 0 : 2;
    nw = (dq.size() + wb - 1) / wb;
    for (int w = 0; w < nw; w++) begin
      e.d = '0;
      for (int k = 0; k < wb; k++) begin
        idx = w * wb + k;
        if (idx < dq.size()) e.d[8*k +: 8] = dq[idx];
      end
      e.a = (addr >> sh) + w;
      if (s) q1.push_back(e); else q4.push_back(e);
    end
  endtask

  // Bytes go out back-to-back, one per cycle.
  task automatic send(input bit s, input int n);
    for (int i = 0; i < n; i++) begin
      if (s) begin v1 = 1'b1; b1 = fq[i]; end
      else   begin v4 = 1'b1; b4 = fq[i]; end
      @(posedge clk); #1;
    end
    v1 = 1'b0;
    v4 = 1'b0;
  endtask

  task automatic get_reply(input bit s, input int hold);
    logic [7:0] exp;
    int         n;
    exp = rq.pop_front();
    n   = 0;
    while (!o_tv(s) && n < 200) begin @(posedge clk); #1; n++; end
    chk("reply_valid", o_tv(s), 1);
    chk("reply_byte", o_tb(s), exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", o_tv(s), 1);
      chk("hold_byte", o_tb(s), exp);
    end
    if (s) rdy1 = 1'b1; else rdy4 = 1'b1;
    @(posedge clk); #1;
    rdy1 = 1'b0;
    rdy4 = 1'b0;
    chk("done_pulse", o_done(s), 1);
    chk("tx_valid_dropped", o_tv(s), 0);
    chk("active_dropped", o_act(s), 0);
    @(posedge clk); #1;
    chk("done_single", o_done(s), 0);
  endtask

  initial begin
    r4 = 1'b0; r1 = 1'b0;
    v4 = 1'b0; v1 = 1'b0; b4 = '0; b1 = '0; rdy4 = 1'b0; rdy1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", t4v, 0);
    chk("rst_tx_byte", t4b, 0);
    chk("rst_active", act4, 0);
    chk("rst_addr", fa4, 0);
    chk("rst_data", fd4, 0);
    chk("rst_wen", w4, 0);
    chk("rst_done", d4, 0);
    chk("rst_err", e4, 0);
    chk("rst_w1_active", act1, 0);
    r4 = 1'b1; r1 = 1'b1;
    @(posedge clk); #1;

    // two full words
    dq = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    build_frame(32'h10, 0); push_exp(0, 32'h10); rq.push_back(8'h55);
    send(0, fq.size());
    get_reply(0, 0);
    chk("t1_err", e4, 0);

    // partial final word zero-padded
    dq = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    build_frame(32'h103, 0); push_exp(0, 32'h103); rq.push_back(8'h55);
    send(0, fq.size());
    get_reply(0, 0);

    // bad checksum: writes still land, NAK, sticky error
    dq = {};
    for (int i = 0; i < 8; i++) dq.push_back(8'(i * 37 + 9));
    build_frame(32'h40, 1); push_exp(0, 32'h40); rq.push_back(8'hEE);
    send(0, fq.size());
    get_reply(0, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("t3_err_sticky", e4, 1);

    // timeout after two data bytes: no write, NAK
    build_frame(32'h200, 0); rq.push_back(8'hEE);
    send(0, 11);
    chk("t4_err_cleared", e4, 0);
    chk("t4_active", act4, 1);
    get_reply(0, 0);
    chk("t4_err_set", e4, 1);

    // LEN=0 with slow reply sink
    dq = {};
    build_frame(32'h300, 0); rq.push_back(8'h55);
    send(0, fq.size());
    get_reply(0, 20);
    chk("t5_err", e4, 0);

    // byte-wide words
    dq = {8'hA1, 8'hB2, 8'hC3};
    build_frame(32'h20, 0); push_exp(1, 32'h20); rq.push_back(8'h55);
    send(1, fq.size());
    get_reply(1, 0);

    // reset mid-DATA: two writes land, then everything clears, no reply
    dq = {};
    for (int i = 0; i < 8; i++) dq.push_back(8'(8'h70 + i));
    build_frame(32'h50, 0);
    e1w.a = 32'h50; e1w.d = 64'h70; q1.push_back(e1w);
    e1w.a = 32'h51; e1w.d = 64'h71; q1.push_back(e1w);
    send(1, 11);
    @(negedge clk);
    chk("t6_active_before_rst", act1, 1);
    #1 r1 = 1'b0;
    #1;
    chk("t6_rst_active", act1, 0);
    chk("t6_rst_wen", w1, 0);
    chk("t6_rst_addr", fa1, 0);
    chk("t6_rst_data", fd1, 0);
    chk("t6_rst_tx_valid", t1v, 0);
    repeat (3) @(posedge clk);
    #1 r1 = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    chk("t6_no_reply", t1v, 0);
    chk("t6_idle_active", act1, 0);

    chk("q4_drained", q4.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
